// File: rtl/mem_stage_unit.sv
// mem_stage_unit: MEM stage of the 5-stage MIPS pipeline.
//   Resolves branches combinationally, performs word loads/stores against an
//   internal word-addressed data memory with MEM_LATENCY cycles per access,
//   and registers the MEM/WB fields. Raises o_stall while an access is still
//   in progress so upstream holds PC, IF/ID, ID/EX and EX/MEM.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   i_alu_result                  byte address (load/store) or ALU value
//   i_read_rb_2                   store data
//   i_branch_address              branch target
//   i_inst_mux_br_write_address   destination register
//   i_zf, i_branch                zero flag, branch instruction
//   i_memWrite, i_memToReg        store request, load request / WB select
//   i_regWrite                    register write enable
//   o_pc_src, o_branch_target     branch decision and target (combinational)
//   o_stall                       hold upstream (combinational)
//   o_read_data .. o_misaligned   MEM/WB register outputs
module mem_stage_unit #(
  parameter int unsigned MEM_DEPTH   = 64,
  parameter int unsigned MEM_LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] i_alu_result,
  input  logic [31:0] i_read_rb_2,
  input  logic [31:0] i_branch_address,
  input  logic [4:0]  i_inst_mux_br_write_address,
  input  logic        i_zf,
  input  logic        i_branch,
  input  logic        i_memWrite,
  input  logic        i_regWrite,
  input  logic        i_memToReg,
  output logic        o_pc_src,
  output logic [31:0] o_branch_target,
  output logic        o_stall,
  output logic [31:0] o_read_data,
  output logic [31:0] o_alu_result,
  output logic [4:0]  o_write_address,
  output logic        o_regWrite,
  output logic        o_memToReg,
  output logic        o_misaligned
);

  localparam int unsigned AW       = $clog2(MEM_DEPTH);
  localparam int unsigned CW       = (MEM_LATENCY > 2) ? $clog2(MEM_LATENCY) : 1;
  localparam int unsigned CNT_INIT = (MEM_LATENCY > 1) ? MEM_LATENCY - 2 : 0;
  localparam bit          MULTI    = (MEM_LATENCY > 1);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t          r_state, w_state_nxt;
  logic [CW-1:0]   r_cnt, w_cnt_nxt;
  logic            w_hold_en;
  logic            w_complete;

  // Request captured at the start of a multi-cycle access
  logic [31:0]     r_h_alu;
  logic [31:0]     r_h_wdata;
  logic [4:0]      r_h_dest;
  logic            r_h_memWrite;
  logic            r_h_memToReg;
  logic            r_h_regWrite;

  logic [31:0]     r_mem [MEM_DEPTH];

  logic [31:0]     r_read_data;
  logic [31:0]     r_alu_result;
  logic [4:0]      r_write_address;
  logic            r_regWrite;
  logic            r_memToReg;
  logic            r_misaligned;

  logic            w_req;
  logic [31:0]     w_s_alu;
  logic [31:0]     w_s_wdata;
  logic [4:0]      w_s_dest;
  logic            w_s_wr;
  logic            w_s_rd;
  logic            w_s_rw;
  logic            w_s_mis;
  logic [AW-1:0]   w_idx;
  logic [31:0]     w_mem_rdata;

  assign w_req = i_memWrite | i_memToReg;

  // The completing access comes from the hold registers in WAIT, otherwise
  // straight from the EX/MEM inputs.
  always_comb begin
    if (r_state == S_WAIT) begin
      w_s_alu   = r_h_alu;
      w_s_wdata = r_h_wdata;
      w_s_dest  = r_h_dest;
      w_s_wr    = r_h_memWrite;
      w_s_rd    = r_h_memToReg;
      w_s_rw    = r_h_regWrite;
    end else begin
      w_s_alu   = i_alu_result;
      w_s_wdata = i_read_rb_2;
      w_s_dest  = i_inst_mux_br_write_address;
      w_s_wr    = i_memWrite;
      w_s_rd    = i_memToReg;
      w_s_rw    = i_regWrite;
    end
  end

  assign w_s_mis     = (w_s_wr | w_s_rd) & (w_s_alu[1:0] != 2'b00);
  assign w_idx       = w_s_alu[2 +: AW];
  assign w_mem_rdata = r_mem[w_idx];

  // Next-state / stall logic
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_hold_en   = 1'b0;
    w_complete  = 1'b0;
    o_stall     = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_req && MULTI) begin
          o_stall     = 1'b1;
          w_hold_en   = 1'b1;
          w_cnt_nxt   = CW'(CNT_INIT);
          w_state_nxt = S_WAIT;
        end else begin
          w_complete  = 1'b1;
        end
      end
      S_WAIT: begin
        if (r_cnt != '0) begin
          o_stall   = 1'b1;
          w_cnt_nxt = r_cnt - CW'(1);
        end else begin
          w_complete  = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_h_alu      <= '0;
      r_h_wdata    <= '0;
      r_h_dest     <= '0;
      r_h_memWrite <= 1'b0;
      r_h_memToReg <= 1'b0;
      r_h_regWrite <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_hold_en) begin
        r_h_alu      <= i_alu_result;
        r_h_wdata    <= i_read_rb_2;
        r_h_dest     <= i_inst_mux_br_write_address;
        r_h_memWrite <= i_memWrite;
        r_h_memToReg <= i_memToReg;
        r_h_regWrite <= i_regWrite;
      end
    end
  end

  // Memory is not reset; rst gating drops an access abandoned mid-WAIT.
  always_ff @(posedge clk) begin
    if (!rst && w_complete && w_s_wr && !w_s_mis) begin
      r_mem[w_idx] <= w_s_wdata;
    end
  end

  // MEM/WB register; non-completing cycles insert a bubble.
  // Load data is sampled before the same-edge store, giving read-before-write.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_read_data     <= '0;
      r_alu_result    <= '0;
      r_write_address <= '0;
      r_regWrite      <= 1'b0;
      r_memToReg      <= 1'b0;
      r_misaligned    <= 1'b0;
    end else if (w_complete) begin
      r_read_data     <= (w_s_rd && !w_s_mis) ? w_mem_rdata : '0;
      r_alu_result    <= w_s_alu;
      r_write_address <= w_s_dest;
      r_regWrite      <= w_s_rw & ~w_s_mis;
      r_memToReg      <= w_s_rd;
      r_misaligned    <= w_s_mis;
    end else begin
      r_read_data     <= '0;
      r_alu_result    <= '0;
      r_write_address <= '0;
      r_regWrite      <= 1'b0;
      r_memToReg      <= 1'b0;
      r_misaligned    <= 1'b0;
    end
  end

  assign o_pc_src        = i_branch & i_zf & (r_state == S_IDLE);
  assign o_branch_target = i_branch_address;
  assign o_read_data     = r_read_data;
  assign o_alu_result    = r_alu_result;
  assign o_write_address = r_write_address;
  assign o_regWrite      = r_regWrite;
  assign o_memToReg      = r_memToReg;
  assign o_misaligned    = r_misaligned;

endmodule

// File: doc/mem_stage_unit.md
Name: mem_stage_unit

Overview:
MEM stage of the 5-stage MIPS pipeline and the consumer of the EX/MEM buffer outputs. It resolves branches, performs data-memory loads and stores against a word-addressed internal data memory with configurable access latency, and registers the MEM/WB fields. It drives a stall back to the upstream pipeline while a multi-cycle access is in progress.

Parameters:
MEM_DEPTH, 64, data memory depth in 32-bit words (power of 2)
MEM_LATENCY, 2, total cycles per load/store (>=1)

Ports:
clk  input  1  pipeline clock, all state on rising edge
rst  input  1  synchronous, active-high reset
i_alu_result  input  32  byte address (loads/stores) or ALU value
i_read_rb_2  input  32  store data
i_branch_address  input  32  branch target
i_inst_mux_br_write_address  input  5  destination register
i_zf  input  1  ALU zero flag
i_branch  input  1  branch instruction
i_memWrite  input  1  store request
i_regWrite  input  1  register write enable
i_memToReg  input  1  load request / WB mux select
o_pc_src  output  1  take branch (combinational)
o_branch_target  output  32  equals i_branch_address (combinational)
o_stall  output  1  upstream must hold PC, IF/ID, ID/EX, EX/MEM (combinational)
o_read_data  output  32  MEM/WB load data
o_alu_result  output  32  MEM/WB ALU result
o_write_address  output  5  MEM/WB destination register
o_regWrite  output  1  MEM/WB register write enable
o_memToReg  output  1  MEM/WB WB mux select
o_misaligned  output  1  MEM/WB misaligned-access flag

Behaviour:
- req = i_memWrite | i_memToReg; word index = i_alu_result[2 +: log2(MEM_DEPTH)], upper bits ignored (address wraps modulo depth).
- Misaligned = i_alu_result[1:0] != 0 on a req: no write, o_read_data=0, o_regWrite=0, o_misaligned=1 in that MEM/WB slot.
- FSM states IDLE, WAIT; down-counter cnt.
- IDLE, no req: at edge load MEM/WB from inputs (o_read_data=0, o_misaligned=0); 1-cycle latency.
- IDLE, req, MEM_LATENCY==1: access at this edge, load MEM/WB; stay IDLE; o_stall=0.
- IDLE, req, MEM_LATENCY>1: o_stall=1; at edge latch all inputs into hold regs, cnt=MEM_LATENCY-2, go WAIT; MEM/WB loads a bubble (regWrite=0, memToReg=0, misaligned=0, others 0).
- WAIT, cnt!=0: o_stall=1, cnt decrements, MEM/WB bubble.
- WAIT, cnt==0: o_stall=0; at edge perform access from hold regs, load MEM/WB from hold regs, go IDLE. Upstream advances on the same edge. Inputs are ignored throughout WAIT.
- Stall cycles per access = MEM_LATENCY-1; total occupancy = MEM_LATENCY cycles.
- Store: mem[index] <= store data at completion edge. Load: o_read_data <= mem[index] at completion edge.
- memWrite and memToReg both set: store performed, load returns pre-write data (read-before-write).
- o_pc_src = i_branch & i_zf & (state==IDLE). Branch resolves in the same cycle; flush is upstream's responsibility.
- Reset: state IDLE, cnt 0, hold regs 0, all registered outputs 0. Memory contents are not reset.
- Reset during WAIT: pending access abandoned (no write), outputs 0, o_stall=0 next cycle.

Test Plan:
- MEM_LATENCY=2: store 0xDEADBEEF to addr 0x10, then load 0x10 -> o_stall high 1 cycle per op; load's o_read_data=0xDEADBEEF, o_regWrite=1, o_memToReg=1 on the completion edge.
- ALU op (regWrite=1, dest 5, result 0x1234), no req -> next edge o_alu_result=0x1234, o_write_address=5, o_stall never high.
- Branch=1, zf=1, target 0x40 -> o_pc_src=1, o_branch_target=0x40 same cycle; with zf=0 -> o_pc_src=0.
- MEM_LATENCY=4: load -> o_stall high exactly 3 cycles, three bubbles (o_regWrite=0), data on 4th edge; toggling inputs during WAIT has no effect.
- Store to 0x102 (misaligned) -> o_misaligned=1, o_regWrite=0, memory word 0x100 unchanged. Store to MEM_DEPTH*4 -> wraps to word 0.
- Assert rst in WAIT after a store request -> no memory write (reload shows old value), all outputs 0, FSM in IDLE.
